// File: rtl/tb_mmio_pkg.sv
// Purpose: shared register offsets and enums for the testbench MMIO peripheral.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tb_mmio_pkg;

  // Register offsets inside the 64-byte window
  localparam logic [5:0] PRINT_OFS  = 6'h00;
  localparam logic [5:0] RESULT_OFS = 6'h04;
  localparam logic [5:0] EXIT_OFS   = 6'h08;
  localparam logic [5:0] CYC_LO_OFS = 6'h0C;
  localparam logic [5:0] CYC_HI_OFS = 6'h10;
  localparam logic [5:0] LEVEL_OFS  = 6'h14;

  // Kind of deferred event held while characters drain
  typedef enum logic [1:0] {
    EV_PASS,
    EV_FAIL,
    EV_EXIT
  } ev_kind_e;

  // Event sequencer states
  typedef enum logic {
    IDLE,
    DRAIN
  } ev_state_e;

endpackage

// File: rtl/tb_mmio_fifo.sv
// Purpose: synchronous FIFO with full/empty/level status; head is shown combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
module tb_mmio_fifo #(
  parameter  int unsigned DEPTH = 8,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdat,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_level   = r_wptr - r_rptr;
  assign o_rdat    = r_mem[r_rptr[AW-1:0]];

  // Advance read/write pointers; reset empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Storage array needs no reset: contents are only observed when non-empty
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdat;
  end

endmodule

// File: rtl/tb_mmio_periph.sv
// Purpose: OBI-attached stdout/pass/fail/exit peripheral with a 64-bit cycle counter.
// Latency: rvalid one cycle after grant; characters at head one cycle after push; events pulse once the FIFO drains.
// Backpressure: PRINT stalled while FIFO full with no pop; RESULT/EXIT stalled while an event is pending.
module tb_mmio_periph
  import tb_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  input  logic        print_ready_i,
  output logic        print_valid_o,
  output logic [31:0] print_wdata_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [5:0]    w_ofs;
  logic          w_hit, w_is_print, w_is_result, w_is_exit;
  logic          w_event_wr, w_print_stall, w_event_stall;
  logic          w_push, w_pop, w_full, w_empty;
  logic [7:0]    w_head;
  logic [LW-1:0] w_level;
  logic [31:0]   w_rd;
  logic          w_latch, w_fire;
  logic          w_unused_bits;
  ev_state_e     r_state, w_state_nxt;
  ev_kind_e      r_ev_kind;
  logic [31:0]   r_ev_value, r_exit_value, r_rdata, r_hi_q;
  logic          r_rvalid;
  logic [63:0]   r_cycle;

  // Decode: word offset inside the window; byte lanes other than be[0] are irrelevant
  assign w_ofs         = {data_addr_i[5:2], 2'b00};
  assign w_hit         = data_req_i && (data_addr_i[31:6] == BASE_ADDR[31:6]);
  assign w_is_print    = (w_ofs == PRINT_OFS);
  assign w_is_result   = (w_ofs == RESULT_OFS);
  assign w_is_exit     = (w_ofs == EXIT_OFS);
  assign w_unused_bits = ^{data_addr_i[1:0], data_be_i[3:1]};

  assign w_pop         = !w_empty && print_ready_i;
  assign w_event_wr    = data_we_i && (w_is_result || w_is_exit);
  assign w_print_stall = data_we_i && w_is_print && w_full && !w_pop;
  assign w_event_stall = w_event_wr && (r_state == DRAIN);
  assign data_gnt_o    = rst_n && w_hit && !w_print_stall && !w_event_stall;
  assign w_push        = data_gnt_o && data_we_i && w_is_print && data_be_i[0];

  tb_mmio_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdat  (data_wdata_i[7:0]),
    .i_pop   (w_pop),
    .o_rdat  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign print_valid_o = !w_empty;
  assign print_wdata_o = w_empty ? 32'h0 : {24'h0, w_head};

  // Read mux; write-only and unmapped offsets read as zero
  always_comb begin
    w_rd = 32'h0;
    case (w_ofs)
      CYC_LO_OFS: w_rd = r_cycle[31:0];
      CYC_HI_OFS: w_rd = r_hi_q;
      LEVEL_OFS:  w_rd = 32'(w_level);
      default:    w_rd = 32'h0;
    endcase
  end

  // Response one cycle after each grant; the LO read snapshots the upper half
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'h0;
      r_hi_q   <= 32'h0;
    end else begin
      r_rvalid <= data_gnt_o;
      r_rdata  <= (data_gnt_o && !data_we_i) ? w_rd : 32'h0;
      if (data_gnt_o && !data_we_i && (w_ofs == CYC_LO_OFS)) r_hi_q <= r_cycle[63:32];
    end
  end

  assign data_rvalid_o = r_rvalid;
  assign data_rdata_o  = r_rdata;

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cycle <= 64'h0;
    else        r_cycle <= r_cycle + 64'h1;
  end

  // Event state register plus the latched event and the sticky exit code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_ev_kind    <= EV_EXIT;
      r_ev_value   <= 32'h0;
      r_exit_value <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_ev_kind  <= w_is_exit ? EV_EXIT : ((data_wdata_i == PASS_MAGIC) ? EV_PASS : EV_FAIL);
        r_ev_value <= data_wdata_i;
      end
      if (w_fire && (r_ev_kind == EV_EXIT)) r_exit_value <= r_ev_value;
    end
  end

  // Next state: latch on an accepted event write, fire once no character is ahead of it
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_fire      = 1'b0;
    case (r_state)
      IDLE: begin
        if (data_gnt_o && w_event_wr) begin
          w_latch     = 1'b1;
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_empty && !w_push) begin
          w_fire      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  assign tests_passed_o = w_fire && (r_ev_kind == EV_PASS);
  assign tests_failed_o = w_fire && (r_ev_kind == EV_FAIL);
  assign exit_valid_o   = w_fire && (r_ev_kind == EV_EXIT);
  assign exit_value_o   = exit_valid_o ? r_ev_value : r_exit_value;

endmodule

// File: tb/tb_tb_mmio_periph.sv
// Purpose: directed scoreboard bench for tb_mmio_periph (bus responses, character stream, events).
// Latency: checks rvalid at grant+1, characters at push+1, event pulses after drain.
// Backpressure: exercises full-FIFO stalls and event stalls while draining.
module tb_tb_mmio_periph;
  import tb_mmio_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_req_i = 1'b0;
  logic        data_gnt_o;
  logic [31:0] data_addr_i = 32'h0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = 4'h0;
  logic [31:0] data_wdata_i = 32'h0;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        print_ready_i = 1'b1;
  logic        print_valid_o;
  logic [31:0] print_wdata_o;
  logic        tests_passed_o, tests_failed_o, exit_valid_o;
  logic [31:0] exit_value_o;

  tb_mmio_periph #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (8),
    .PASS_MAGIC (32'd123456789)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_req_i     (data_req_i),
    .data_gnt_o     (data_gnt_o),
    .data_addr_i    (data_addr_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_wdata_i   (data_wdata_i),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .print_ready_i  (print_ready_i),
    .print_valid_o  (print_valid_o),
    .print_wdata_o  (print_wdata_o),
    .tests_passed_o (tests_passed_o),
    .tests_failed_o (tests_failed_o),
    .exit_valid_o   (exit_valid_o),
    .exit_value_o   (exit_value_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    ev_kind_e    k;
    logic [31:0] v;
  } ev_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [63:0] rcyc;
  logic [31:0] rd_q[$];
  logic [7:0]  ch_q[$];
  ev_t         ev_q[$];
  int          pop_cyc[$];
  int          ev_cyc[$];
  bit          prev_gnt = 1'b0;

  // Reference cycle counter: cleared by reset, +1 per clock
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rcyc <= 64'h0;
    else        rcyc <= rcyc + 64'h1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: observed at cycle %0d, required none", name, cyc);
  endtask

  // Monitor: pops expected responses, characters and events as the DUT presents them
  always @(negedge clk) begin
    ev_kind_e kact;
    ev_t      e;
    #2;
    if (!rst_n) begin
      prev_gnt = 1'b0;
    end else begin
      chk("rvalid_after_gnt", 64'(data_rvalid_o), 64'(prev_gnt));
      if (data_rvalid_o) begin
        if (rd_q.size() == 0) fail_now("unexpected_rvalid");
        else chk("rdata", 64'(data_rdata_o), 64'(rd_q.pop_front()));
      end else begin
        chk("rdata_idle_zero", 64'(data_rdata_o), 64'h0);
      end
      prev_gnt = data_req_i && data_gnt_o;

      if (print_valid_o && print_ready_i) begin
        if (ch_q.size() == 0) fail_now("unexpected_char");
        else chk("print_char", 64'(print_wdata_o), 64'(ch_q.pop_front()));
        pop_cyc.push_back(cyc);
      end

      if (tests_passed_o || tests_failed_o || exit_valid_o) begin
        chk("single_event", 64'(int'(tests_passed_o) + int'(tests_failed_o) + int'(exit_valid_o)), 64'd1);
        ev_cyc.push_back(cyc);
        kact = tests_passed_o ? EV_PASS : (tests_failed_o ? EV_FAIL : EV_EXIT);
        if (ev_q.size() == 0) fail_now("unexpected_event");
        else begin
          e = ev_q.pop_front();
          chk("event_kind", 64'(kact), 64'(e.k));
          if (e.k == EV_EXIT) chk("exit_value", 64'(exit_value_o), 64'(e.v));
        end
      end
    end
  end

  // One bus transaction; the expected response is queued at the grant
  task automatic op(input logic [5:0] ofs, input logic we, input logic [31:0] wd,
                    input logic [3:0] be, input logic [31:0] exp, input bit use_cyc,
                    output int gc);
    int n = 0;
    @(negedge clk);
    data_req_i   = 1'b1;
    data_addr_i  = BASE + {26'd0, ofs};
    data_we_i    = we;
    data_wdata_i = wd;
    data_be_i    = be;
    #1;
    while (!data_gnt_o && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    gc = cyc;
    if (!data_gnt_o) begin
      fail_now("grant_timeout");
      gc = -1;
    end else begin
      rd_q.push_back(use_cyc ? rcyc[31:0] : exp);
    end
    @(posedge clk);
    #1;
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [5:0] ofs, input logic [31:0] wd, input logic [3:0] be, output int gc);
    op(ofs, 1'b1, wd, be, 32'h0, 1'b0, gc);
  endtask

  task automatic rd(input logic [5:0] ofs, input logic [31:0] exp);
    int g;
    op(ofs, 1'b0, 32'h0, 4'hF, exp, 1'b0, g);
  endtask

  task automatic push_char(input logic [7:0] c);
    int g;
    ch_q.push_back(c);
    wr(PRINT_OFS, {24'h0, c}, 4'hF, g);
  endtask

  task automatic expect_ev(input ev_kind_e k, input logic [31:0] v);
    ev_t e;
    e.k = k;
    e.v = v;
    ev_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int g, g1, g2, g3, n0, n;
    bit done3;

    // Reset values, with a PRINT request pending to show grant is held off
    data_req_i  = 1'b1;
    data_addr_i = BASE;
    data_we_i   = 1'b1;
    data_be_i   = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", 64'(data_gnt_o), 64'h0);
    chk("rst_rvalid", 64'(data_rvalid_o), 64'h0);
    chk("rst_rdata", 64'(data_rdata_o), 64'h0);
    chk("rst_print_valid", 64'(print_valid_o), 64'h0);
    chk("rst_print_wdata", 64'(print_wdata_o), 64'h0);
    chk("rst_pulses", 64'({tests_passed_o, tests_failed_o, exit_valid_o}), 64'h0);
    chk("rst_exit_value", 64'(exit_value_o), 64'h0);
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Cycle counter about 100 cycles after reset
    repeat (98) @(negedge clk);
    op(CYC_LO_OFS, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, g);
    rd(CYC_HI_OFS, 32'h0);

    // HI returns the snapshot from the LO read, not the live upper half
    @(negedge clk);
    force dut.r_cycle = 64'h0000_0000_FFFF_FFFF;
    rd(CYC_LO_OFS, 32'hFFFF_FFFF);
    force dut.r_cycle = 64'h0000_0001_0000_0003;
    rd(CYC_HI_OFS, 32'h0);
    rd(CYC_LO_OFS, 32'h0000_0003);
    rd(CYC_HI_OFS, 32'h0000_0001);
    release dut.r_cycle;

    // 'H','i' back to back with the sink ready
    print_ready_i = 1'b1;
    pop_cyc.delete();
    ch_q.push_back(8'h48);
    wr(PRINT_OFS, 32'h48, 4'hF, g1);
    ch_q.push_back(8'h69);
    wr(PRINT_OFS, 32'h69, 4'hF, g2);
    repeat (3) @(negedge clk);
    chk("hi_back_to_back", 64'(g2), 64'(g1 + 1));
    chk("hi_pop_count", 64'(pop_cyc.size()), 64'd2);
    if (pop_cyc.size() == 2) begin
      chk("H_at_n_plus_1", 64'(pop_cyc[0]), 64'(g1 + 1));
      chk("i_at_n_plus_2", 64'(pop_cyc[1]), 64'(g1 + 2));
    end

    // be[0]=0 drops PRINT; unmapped and write-only offsets read zero
    print_ready_i = 1'b0;
    wr(PRINT_OFS, 32'h41, 4'b1110, g);
    rd(LEVEL_OFS, 32'h0);
    rd(6'h20, 32'h0);
    rd(PRINT_OFS, 32'h0);

    // Fill the FIFO; the 9th PRINT stalls until the first pop
    for (int i = 0; i < 8; i++) push_char(8'h61 + 8'(i));
    rd(LEVEL_OFS, 32'd8);
    @(negedge clk);
    data_req_i   = 1'b1;
    data_addr_i  = BASE;
    data_we_i    = 1'b1;
    data_wdata_i = 32'h7A;
    data_be_i    = 4'hF;
    #1;
    chk("full_stall_gnt0", 64'(data_gnt_o), 64'h0);
    @(negedge clk);
    #1;
    chk("full_stall_gnt1", 64'(data_gnt_o), 64'h0);
    @(negedge clk);
    pop_cyc.delete();
    print_ready_i = 1'b1;
    #1;
    chk("gnt_on_pop", 64'(data_gnt_o), 64'h1);
    g = cyc;
    ch_q.push_back(8'h7A);
    rd_q.push_back(32'h0);
    @(posedge clk);
    #1;
    data_req_i = 1'b0;
    data_we_i  = 1'b0;
    #3;
    chk("first_pop_same_cycle", 64'(pop_cyc.size() > 0 ? pop_cyc[0] : -1), 64'(g));
    n = 0;
    while (print_valid_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("full_drained", 64'(print_valid_o), 64'h0);

    // PASS is held back behind three buffered characters
    print_ready_i = 1'b0;
    ev_cyc.delete();
    push_char(8'h31);
    push_char(8'h32);
    push_char(8'h33);
    expect_ev(EV_PASS, 32'd123456789);
    wr(RESULT_OFS, 32'd123456789, 4'hF, g);
    repeat (5) @(negedge clk);
    chk("pass_held", 64'(ev_cyc.size()), 64'd0);
    pop_cyc.delete();
    print_ready_i = 1'b1;
    repeat (6) @(negedge clk);
    chk("pass_pops", 64'(pop_cyc.size()), 64'd3);
    chk("pass_count", 64'(ev_cyc.size()), 64'd1);
    if (pop_cyc.size() == 3 && ev_cyc.size() == 1)
      chk("pass_after_last_pop", 64'(ev_cyc[0]), 64'(pop_cyc[2] + 1));

    // FAIL and EXIT with an empty FIFO pulse the cycle after the write
    ev_cyc.delete();
    expect_ev(EV_FAIL, 32'd5);
    wr(RESULT_OFS, 32'd5, 4'hF, g1);
    repeat (3) @(negedge clk);
    expect_ev(EV_EXIT, 32'd7);
    wr(EXIT_OFS, 32'd7, 4'hF, g2);
    repeat (3) @(negedge clk);
    chk("fail_exit_count", 64'(ev_cyc.size()), 64'd2);
    if (ev_cyc.size() == 2) begin
      chk("fail_at_n_plus_1", 64'(ev_cyc[0]), 64'(g1 + 1));
      chk("exit_at_n_plus_1", 64'(ev_cyc[1]), 64'(g2 + 1));
    end
    chk("exit_value_holds", 64'(exit_value_o), 64'd7);

    // A second EXIT during DRAIN is stalled until the first one fires
    print_ready_i = 1'b0;
    ev_cyc.delete();
    push_char(8'h78);
    expect_ev(EV_EXIT, 32'd9);
    wr(EXIT_OFS, 32'd9, 4'hF, g);
    expect_ev(EV_EXIT, 32'd10);
    done3 = 1'b0;
    fork
      begin
        wr(EXIT_OFS, 32'd10, 4'hF, g3);
        done3 = 1'b1;
      end
    join_none
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("drain_exit_stall", 64'(data_gnt_o), 64'h0);
    end
    @(negedge clk);
    pop_cyc.delete();
    print_ready_i = 1'b1;
    repeat (8) @(negedge clk);
    chk("stalled_exit_done", 64'(done3), 64'h1);
    chk("drain_exit_count", 64'(ev_cyc.size()), 64'd2);
    if (ev_cyc.size() == 2 && pop_cyc.size() == 1) begin
      chk("exit9_after_pop", 64'(ev_cyc[0]), 64'(pop_cyc[0] + 1));
      chk("exit10_after_gnt", 64'(ev_cyc[1]), 64'(g3 + 1));
    end
    chk("exit_value_final", 64'(exit_value_o), 64'd10);

    // Reset during DRAIN with four characters queued discards everything
    print_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_char(8'h50 + 8'(i));
    expect_ev(EV_EXIT, 32'h55);
    wr(EXIT_OFS, 32'h55, 4'hF, g);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_print_valid", 64'(print_valid_o), 64'h0);
    chk("mid_rst_print_wdata", 64'(print_wdata_o), 64'h0);
    chk("mid_rst_rvalid", 64'(data_rvalid_o), 64'h0);
    chk("mid_rst_pulses", 64'({tests_passed_o, tests_failed_o, exit_valid_o}), 64'h0);
    chk("mid_rst_exit_value", 64'(exit_value_o), 64'h0);
    ch_q.delete();
    ev_q.delete();
    rd_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    print_ready_i = 1'b1;
    n0 = ev_cyc.size();
    pop_cyc.delete();
    repeat (10) @(negedge clk);
    chk("post_rst_no_char", 64'(pop_cyc.size()), 64'd0);
    chk("post_rst_no_event", 64'(ev_cyc.size()), 64'(n0));
    chk("post_rst_exit_value", 64'(exit_value_o), 64'h0);
    rd(LEVEL_OFS, 32'h0);

    repeat (3) @(negedge clk);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    chk("ch_q_drained", 64'(ch_q.size()), 64'd0);
    chk("ev_q_drained", 64'(ev_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tb_mmio_periph.md
# tb_mmio_periph

Memory-mapped testbench peripheral that sits on the core data bus inside the CV32E40P simulation subsystem. It decodes word writes into the stdout character stream and the pass/fail/exit signals consumed by the testbench top, and exposes a 64-bit cycle counter and print-FIFO level for software to read. Characters are buffered in a FIFO, and result/exit events are held back until every earlier character has been emitted.

## Interface
- BASE_ADDR, 32'h1000_0000: base of the 64-byte register window; addr[31:6] compared.
- FIFO_DEPTH, 8: print FIFO entries, power of two, ≥2.
- PASS_MAGIC, 32'd123456789: TEST_RESULT value meaning pass.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- data_req_i  in  1  OBI request.
- data_gnt_o  out  1  OBI grant; the transaction is accepted when req & gnt.
- data_addr_i  in  32  byte address.
- data_we_i  in  1  write enable.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  write data.
- data_rvalid_o  out  1  response valid.
- data_rdata_o  out  32  read data.
- print_ready_i  in  1  sink accepts a character.
- print_valid_o  out  1  character valid.
- print_wdata_o  out  32  character in [7:0], zero-extended.
- tests_passed_o  out  1  one-cycle pulse.
- tests_failed_o  out  1  one-cycle pulse.
- exit_valid_o  out  1  one-cycle pulse.
- exit_value_o  out  32  exit code; holds its value after the pulse.

## Operation
- Register map (offset):
  - 0x00 PRINT (W): push wdata[7:0] into the FIFO.
  - 0x04 TEST_RESULT (W): value == PASS_MAGIC schedules a pass; any other value schedules a fail.
  - 0x08 EXIT (W): schedule exit with value = wdata.
  - 0x0C CYCLE_LO (R): counter[31:0]; the same read snapshots counter[63:32] into hi_q.
  - 0x10 CYCLE_HI (R): hi_q.
  - 0x14 LEVEL (R): FIFO occupancy, zero-extended.
- Unmapped offsets and writes to read-only registers are accepted with no effect; reads of unmapped or write-only registers return 0.
- Byte enables are ignored except on PRINT: when be[0]=0 the write is dropped.
- Cycle counter: 64-bit, cleared by reset, increments every cycle, wraps at 2^64.
- FIFO: the head drives print_wdata_o[7:0] with print_valid_o = !empty. An entry pops on valid & ready.
  - A push and a pop in the same cycle leave the level unchanged, including when the FIFO is full.
- Event FSM, states IDLE and DRAIN:
  - IDLE: a TEST_RESULT or EXIT write latches the event kind and value, then moves to DRAIN.
  - DRAIN: once the FIFO is empty and no push is occurring this cycle, pulse the latched output for one cycle and return to IDLE.
  - TEST_RESULT → tests_passed_o or tests_failed_o; EXIT → exit_valid_o, with exit_value_o updated in the same cycle.
- Outputs when the FIFO is empty in IDLE: an event written at cycle N pulses at N+1.

## Timing
- data_gnt_o is combinational from req/addr/we and state:
  - Deasserted for a PRINT write while the FIFO is full and no pop occurs this cycle.
  - Deasserted for a TEST_RESULT or EXIT write while the FSM is in DRAIN.
  - Asserted otherwise.
- data_rvalid_o goes high exactly one cycle after each grant, for both reads and writes. data_rdata_o is valid only with rvalid and is 0 otherwise.
- Back-to-back grants are supported, one per cycle.
- Reset values: gnt 0, rvalid 0, rdata 0, print_valid 0, print_wdata 0, all pulses 0, exit_value 0, FSM in IDLE, FIFO empty, counter 0, hi_q 0.
- Reset asserted mid-drain discards the pending event and all buffered characters.

## Structure
- Package tb_mmio_pkg holds:
  - the offset localparams (PRINT_OFS, RESULT_OFS, EXIT_OFS, CYC_LO_OFS, CYC_HI_OFS, LEVEL_OFS);
  - the event-kind enum (EV_PASS, EV_FAIL, EV_EXIT);
  - the FSM state enum.
- One sub-module, tb_mmio_fifo: a synchronous FIFO with full, empty and level outputs, instantiated once.

## Test plan
- Write PRINT 'H', 'i' with print_ready=1 → print_valid at cycles N+1 and N+2 with data 0x48 then 0x69; rvalid one cycle after each grant.
- Hold print_ready=0 and issue 9 PRINT writes with FIFO_DEPTH=8 → the 9th is not granted and LEVEL reads 8. Raise ready → the 9th is granted in the cycle of the first pop.
- Push 3 characters with ready=0, then write TEST_RESULT=123456789 → no pulse. Release ready → tests_passed_o pulses for one cycle, the cycle after the last character pops.
- Write TEST_RESULT=5 → tests_failed_o pulses. Write EXIT=7 → exit_valid_o pulses with exit_value_o=7. During DRAIN, a second EXIT write is stalled (gnt=0).
- After 100 cycles out of reset, read CYCLE_LO then CYCLE_HI → LO ≈ 100 and HI = 0. Force the counter to 2^32-1 before the LO read → HI returns the snapshot taken at the LO read.
- Assert rst_n low during DRAIN with 4 characters queued → all outputs go to reset values immediately. After release, no pulse and no character appears.
